// File: rtl/regfile_pkg.sv
// Shared types for the register-file write arbiter: write-back entry and grant encoding.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 3;  // holds 0..4 queued entries
  localparam int NUM_REQ    = 2;  // 0 = ALU, 1 = MEM
  localparam int NUM_PROBES = 2;  // ReadReg1, ReadReg2

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_t;
endpackage

// File: rtl/wb_queue.sv
// Per-requester write-back FIFO: circular buffer with per-slot valid bits so
// in-flight destination registers can be matched against datapath reads.
module wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      push_i,
  input  wb_entry_t                                 push_entry_i,
  input  logic                                      pop_i,
  input  logic [NUM_PROBES-1:0][REG_ADDR_W-1:0]     probe_i,
  output logic [CNT_W-1:0]                          count_o,
  output wb_entry_t                                 head_o,
  output logic [NUM_PROBES-1:0]                     hit_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t [DEPTH-1:0] ent_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = bump(wr_ptr_q);
    if (pop_i)  rd_ptr_d = bump(rd_ptr_q);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Clear-on-pop precedes set-on-push; the two slots differ unless the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop_i) vld_q[rd_ptr_q] <= 1'b0;
      if (push_i) begin
        ent_q[wr_ptr_q] <= push_entry_i;
        vld_q[wr_ptr_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    hit_o = '0;
    for (int p = 0; p < NUM_PROBES; p++)
      for (int i = 0; i < DEPTH; i++)
        if (vld_q[i] && ent_q[i].rd == probe_i[p]) hit_o[p] = 1'b1;
  end

  assign count_o = count_q;
  assign head_o  = ent_q[rd_ptr_q];
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load write-backs into one registered register-file write port
// with round-robin arbitration and pending-write scoreboarding for reads.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [3:0]            pending
);
  logic      [NUM_REQ-1:0]                  req_vld, ready, push, gnt, ne;
  wb_entry_t [NUM_REQ-1:0]                  req_ent, head;
  logic      [NUM_REQ-1:0][CNT_W-1:0]       cnt;
  logic      [NUM_REQ-1:0][NUM_PROBES-1:0]  hit;
  logic      [NUM_PROBES-1:0][REG_ADDR_W-1:0] probe;

  gnt_t      last_q, last_d;
  logic      wr_vld_q;
  wb_entry_t wr_ent_q;

  assign req_vld  = {mem_valid, alu_valid};
  assign req_ent  = {{mem_reg, mem_data}, {alu_reg, alu_data}};
  assign probe    = {ReadReg2, ReadReg1};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    // Writes to r0 complete the handshake but are dropped here.
    assign ready[g] = cnt[g] < CNT_W'(DEPTH);
    assign push[g]  = req_vld[g] && ready[g] && (req_ent[g].rd != '0);
    assign ne[g]    = cnt[g] != '0;

    wb_queue #(.DEPTH(DEPTH)) u_q (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push[g]),
      .push_entry_i (req_ent[g]),
      .pop_i        (gnt[g]),
      .probe_i      (probe),
      .count_o      (cnt[g]),
      .head_o       (head[g]),
      .hit_o        (hit[g])
    );
  end

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (ne[0] && (!ne[1] || last_q == GNT_MEM)) begin
      gnt[0] = 1'b1;
      last_d = GNT_ALU;
    end else if (ne[1]) begin
      gnt[1] = 1'b1;
      last_d = GNT_MEM;
    end
  end

  // last_grant resets to MEM so the ALU wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      wr_ent_q <= '0;
      last_q   <= GNT_MEM;
    end else begin
      wr_vld_q <= |gnt;
      last_q   <= last_d;
      if (|gnt) wr_ent_q <= gnt[1] ? head[1] : head[0];
    end
  end

  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign RegWrite  = wr_vld_q;
  assign WriteReg  = wr_ent_q.rd;
  assign WriteData = wr_ent_q.data;

  assign busy1 = (ReadReg1 != '0) &&
                 (hit[0][0] || hit[1][0] || (wr_vld_q && wr_ent_q.rd == ReadReg1));
  assign busy2 = (ReadReg2 != '0) &&
                 (hit[0][1] || hit[1][1] || (wr_vld_q && wr_ent_q.rd == ReadReg2));

  assign pending = 4'(cnt[0]) + 4'(cnt[1]) + 4'(wr_vld_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic        busy1, busy2;
  logic [3:0]  pending;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .busy1(busy1), .busy2(busy2),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    ReadReg1 = '0; ReadReg2 = '0;
    do_reset();

    // Reset state
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_writereg", 32'(WriteReg), 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);

    // Single ALU write r5 = 12, two-edge latency
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'd12; ReadReg1 = 5'd5;
    step();
    idle_in();
    chk("t1_queued_rw", 32'(RegWrite), 32'd0);
    chk("t1_queued_pend", 32'(pending), 32'd1);
    chk("t1_queued_busy1", 32'(busy1), 32'd1);
    step();
    chk("t1_issue_rw", 32'(RegWrite), 32'd1);
    chk("t1_issue_reg", 32'(WriteReg), 32'd5);
    chk("t1_issue_data", WriteData, 32'd12);
    chk("t1_issue_pend", 32'(pending), 32'd1);
    step();
    chk("t1_done_rw", 32'(RegWrite), 32'd0);
    chk("t1_done_pend", 32'(pending), 32'd0);
    chk("t1_done_busy1", 32'(busy1), 32'd0);
    ReadReg1 = '0;

    // Round-robin: ALU 1,2 / MEM 3,4 -> 1,3,2,4
    do_reset();
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h33;
    step();
    chk("t2_e1_pend", 32'(pending), 32'd2);
    chk("t2_e1_rw", 32'(RegWrite), 32'd0);
    alu_reg = 5'd2; alu_data = 32'h22;
    mem_reg = 5'd4; mem_data = 32'h44;
    step();
    idle_in();
    chk("t2_o1_reg", 32'(WriteReg), 32'd1);
    chk("t2_o1_data", WriteData, 32'h11);
    chk("t2_o1_rw", 32'(RegWrite), 32'd1);
    chk("t2_full_pend", 32'(pending), 32'd4);
    chk("t2_mem_stall", 32'(mem_ready), 32'd0);
    chk("t2_alu_ready", 32'(alu_ready), 32'd1);
    step();
    chk("t2_o2_rw", 32'(RegWrite), 32'd1);
    chk("t2_o2_reg", 32'(WriteReg), 32'd3);
    chk("t2_o2_data", WriteData, 32'h33);
    step();
    chk("t2_o3_rw", 32'(RegWrite), 32'd1);
    chk("t2_o3_reg", 32'(WriteReg), 32'd2);
    step();
    chk("t2_o4_rw", 32'(RegWrite), 32'd1);
    chk("t2_o4_reg", 32'(WriteReg), 32'd4);
    chk("t2_o4_data", WriteData, 32'h44);
    step();
    chk("t2_end_rw", 32'(RegWrite), 32'd0);
    chk("t2_end_pend", 32'(pending), 32'd0);

    // Write to r0 is discarded
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'd99;
    chk("t3_ready", 32'(alu_ready), 32'd1);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_rw_%0d", i), 32'(RegWrite), 32'd0);
      chk($sformatf("t3_pend_%0d", i), 32'(pending), 32'd0);
      step();
    end

    // busy tracking for MEM write r7
    ReadReg1 = 5'd7; ReadReg2 = 5'd0;
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h77;
    #1;
    chk("t4_pre_busy1", 32'(busy1), 32'd0);
    step();
    idle_in();
    chk("t4_q_busy1", 32'(busy1), 32'd1);
    chk("t4_q_busy2", 32'(busy2), 32'd0);
    chk("t4_q_rw", 32'(RegWrite), 32'd0);
    step();
    chk("t4_o_rw", 32'(RegWrite), 32'd1);
    chk("t4_o_busy1", 32'(busy1), 32'd1);
    chk("t4_o_busy2", 32'(busy2), 32'd0);
    step();
    chk("t4_d_rw", 32'(RegWrite), 32'd0);
    chk("t4_d_busy1", 32'(busy1), 32'd0);
    chk("t4_d_busy2", 32'(busy2), 32'd0);
    ReadReg1 = '0;

    // Reset mid-stream drops queued writes
    alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_reg = 5'd20; mem_data = 32'hB0;
    step();
    alu_reg = 5'd11; mem_reg = 5'd21;
    step();
    idle_in();
    chk("t5_busy_rw", 32'(RegWrite), 32'd1);
    chk("t5_busy_pend", 32'(pending), 32'd4);
    rst = 1'b1;
    #1;
    chk("t5_async_rw", 32'(RegWrite), 32'd0);
    chk("t5_async_pend", 32'(pending), 32'd0);
    chk("t5_async_reg", 32'(WriteReg), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_rel_alu_ready", 32'(alu_ready), 32'd1);
    chk("t5_rel_mem_ready", 32'(mem_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_no_issue_%0d", i), 32'(RegWrite), 32'd0);
      chk($sformatf("t5_pend_%0d", i), 32'(pending), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries per requester queue; legal values 1..4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Ports: alu_valid / mem_valid  input  1  requester 0 (ALU) / requester 1 (load) has a write.
REQ-005 Ports: alu_ready / mem_ready  output  1  queue can accept this cycle.
REQ-006 Ports: alu_reg / mem_reg  input  5  destination register number.
REQ-007 Ports: alu_data / mem_data  input  32  write value.
REQ-008 Port: RegWrite  output  1  register-file write enable, registered.
REQ-009 Port: WriteReg  output  5  register-file write address, registered.
REQ-010 Port: WriteData  output  32  register-file write data, registered.
REQ-011 Ports: ReadReg1, ReadReg2  input  5  register numbers currently read by the datapath.
REQ-012 Ports: busy1, busy2  output  1  read register has a pending write.
REQ-013 Port: pending  output  4  total entries queued plus output stage occupancy.

Function
REQ-014 A write SHALL be accepted on a rising edge when valid and ready are both high.
REQ-015 ready SHALL depend only on registered queue count: high iff count < DEPTH; no same-cycle bypass when full and dequeuing.
REQ-016 Accepted writes with reg = 0 SHALL complete the handshake but be discarded (never queued, never issued).
REQ-017 Each requester queue SHALL be strict FIFO; no ordering is guaranteed between requesters.
REQ-018 Each cycle with at least one non-empty queue, exactly one head SHALL be popped and loaded into the output stage at the next edge.
REQ-019 Arbitration SHALL be round-robin via a last_grant register: both non-empty -> grant the requester not last granted; one non-empty -> grant it; last_grant updates on every grant.
REQ-020 Output stage: RegWrite = 1 with WriteReg/WriteData of the granted entry for exactly one cycle per grant; RegWrite = 0 when no grant.
REQ-021 Latency: write accepted at edge E into empty queues SHALL appear on RegWrite in the cycle after edge E+1 (two edges).
REQ-022 Sustained throughput SHALL be one register write per cycle with no bubble while any queue is non-empty.
REQ-023 busyN SHALL be combinational: high iff ReadRegN != 0 and equals the reg of any valid queue entry or of the output stage while RegWrite = 1.
REQ-024 pending SHALL equal queued entries of both queues plus RegWrite, updated each edge.
REQ-025 Simultaneous accept on both requesters and a pop SHALL all take effect in the same edge with counts exact.

Reset
REQ-026 rst high SHALL immediately clear both queues, output stage, and set RegWrite = 0, WriteReg = 0, WriteData = 0, pending = 0, last_grant = 1 (ALU wins first).
REQ-027 Reset during operation SHALL drop all queued writes without issuing them; ready SHALL be high on the first cycle after rst falls.

Structure
REQ-028 Shared package regfile_pkg SHALL hold REG_ADDR_W = 5, DATA_W = 32 and typedef wb_entry_t {reg, data}.
REQ-029 Per-requester FIFO SHALL be sub-module wb_queue (push/pop/count/head/entry-match vector), instantiated twice.

Verification
REQ-030 Reset then single ALU write reg 5 = 12 -> RegWrite high with WriteReg 5, WriteData 12 two edges after accept; pending 1 -> 0.
REQ-031 Both requesters valid every cycle, ALU regs 1,2 / MEM regs 3,4 -> issue order 1,3,2,4, one per cycle, then ready stalls at DEPTH.
REQ-032 ALU write to reg 0 with data 99 -> handshake completes, RegWrite never asserted, pending stays 0.
REQ-033 MEM write reg 7 queued, ReadReg1 = 7, ReadReg2 = 0 -> busy1 = 1 until RegWrite cycle ends, busy2 = 0 throughout.
REQ-034 Fill both queues, assert rst mid-stream -> RegWrite 0 immediately, no queued write ever issued, pending 0, both ready high after release.
